pc_fetch_ctrl: RTL and testbench

//  PC register + instruction-fetch controller for the RISC-V core. Drives the current PC to
//  the sequential-PC adder (pc_out + 4) and takes the adder result back as seq_pc_in.

---
 rtl/pc_fetch_ctrl_pkg.sv | 13 +
 rtl/pc_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package pc_fetch_ctrl_pkg;
   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      REQ   = 3'd1,
      OUT   = 3'd2,
      DRAIN = 3'd3,
      HALT  = 3'd4
   } fetch_state_e;

   localparam logic [31:0] NOP_INSN             = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-entry fetch controller: req/ack to imem, one buffered
// instruction handed downstream with valid/ready, redirects and sticky traps.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int                XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter int                TIMEOUT      = 16
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] pc_out,
   input  logic [XLEN-1:0] seq_pc_in,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_out,
   output logic [XLEN-1:0] inst_pc,
   output logic            trap_misalign,
   output logic            trap_timeout
);
   localparam int CW = $clog2(TIMEOUT + 1);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [CW-1:0]   cnt;
   logic            redir_bad;

   assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
   // pc only moves when leaving DRAIN, so the abandoned address is held for free
   assign imem_addr = pc;
   assign pc_out    = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= BOOT;
         pc            <= RESET_VECTOR;
         pc_next       <= RESET_VECTOR;
         cnt           <= '0;
         imem_req      <= 1'b0;
         inst_valid    <= 1'b0;
         inst_out      <= NOP_INSN;
         inst_pc       <= '0;
         trap_misalign <= 1'b0;
         trap_timeout  <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state    <= REQ;
               imem_req <= 1'b1;
               cnt      <= '0;
            end
            REQ, DRAIN: begin
               if (redir_bad) begin
                  trap_misalign <= 1'b1;
                  inst_valid    <= 1'b0;
                  imem_req      <= 1'b0;
                  state         <= HALT;
               end else if (imem_ack) begin
                  cnt <= '0;
                  if (state == DRAIN) begin
                     // a redirect landing with the ack is the newest target
                     pc    <= redirect_valid ? redirect_target : pc_next;
                     state <= REQ;
                  end else if (redirect_valid) begin
                     pc <= redirect_target;
                  end else begin
                     inst_out   <= imem_rdata;
                     inst_pc    <= pc;
                     inst_valid <= 1'b1;
                     imem_req   <= 1'b0;
                     state      <= OUT;
                  end
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  trap_timeout <= 1'b1;
                  imem_req     <= 1'b0;
                  state        <= HALT;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (redirect_valid) begin
                     pc_next <= redirect_target;
                     state   <= DRAIN;
                  end
               end
            end
            OUT: begin
               if (redir_bad) begin
                  trap_misalign <= 1'b1;
                  inst_valid    <= 1'b0;
                  imem_req      <= 1'b0;
                  state         <= HALT;
               end else if (redirect_valid || inst_ready) begin
                  pc         <= redirect_valid ? redirect_target : seq_pc_in;
                  inst_valid <= 1'b0;
                  imem_req   <= 1'b1;
                  cnt        <= '0;
                  state      <= REQ;
               end
            end
            HALT: begin
               imem_req   <= 1'b0;
               inst_valid <= 1'b0;
            end
            default: begin
               imem_req   <= 1'b0;
               inst_valid <= 1'b0;
               state      <= HALT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: inputs change and outputs are sampled on negedge.
module tb_pc_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_out, seq_pc_in, redirect_target, imem_addr, inst_pc;
   logic        redirect_valid, imem_req, imem_ack, inst_valid, inst_ready;
   logic [31:0] imem_rdata, inst_out;
   logic        trap_misalign, trap_timeout;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   assign seq_pc_in = pc_out + 32'd4;   // external adder

   pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .pc_out(pc_out), .seq_pc_in(seq_pc_in),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_out(inst_out), .inst_pc(inst_pc),
      .trap_misalign(trap_misalign), .trap_timeout(trap_timeout));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // reset, release, and land at the negedge of the first REQ cycle
   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
      imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
      imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      tick(); tick();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
      checks++; if (inst_out !== 32'h13) begin errors++; $display("FAIL reset_inst got %h exp 00000013", inst_out); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
      checks++; if ({trap_misalign, trap_timeout} !== 2'b00) begin errors++; $display("FAIL reset_traps got %b%b exp 00", trap_misalign, trap_timeout); end
      rst = 1'b0;
      tick();   // BOOT -> REQ
      checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL boot_to_req req %b valid %b exp 1 0", imem_req, inst_valid); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d req %b addr %h exp 1 %h", i, imem_req, imem_addr, 32'(4 * i)); end
         imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i); inst_ready = 1'b1;
         tick();
         imem_ack = 1'b0;
         checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_out !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL seq_out%0d valid %b pc %h inst %h exp 1 %h %h", i, inst_valid, inst_pc, inst_out, 32'(4 * i), 32'hA000_0000 + 32'(i)); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_req_low%0d got %b exp 0", i, imem_req); end
         tick();
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_stall();
      // in REQ at pc 0x10
      imem_ack = 1'b1; imem_rdata = 32'hBEEF_0013;
      tick();
      imem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (inst_valid !== 1'b1 || inst_out !== 32'hBEEF_0013 || inst_pc !== 32'h10 || imem_req !== 1'b0 || pc_out !== 32'h10) begin errors++; $display("FAIL stall%0d valid %b inst %h ipc %h req %b pc %h exp 1 beef0013 10 0 10", i, inst_valid, inst_out, inst_pc, imem_req, pc_out); end
         tick();
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || inst_valid !== 1'b0) begin errors++; $display("FAIL stall_release req %b addr %h valid %b exp 1 14 0", imem_req, imem_addr, inst_valid); end
   endtask

   task automatic test_redirect_drain();
      // REQ at 0x14, redirect without ack -> DRAIN
      redirect_valid = 1'b1; redirect_target = 32'h100;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL drain_hold%0d req %b addr %h exp 1 14", i, imem_req, imem_addr); end
         tick();
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0 || inst_out !== 32'hBEEF_0013) begin errors++; $display("FAIL drain_exit req %b addr %h valid %b inst %h exp 1 100 0 beef0013", imem_req, imem_addr, inst_valid, inst_out); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0011;
      tick();
      imem_ack = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_out !== 32'h11) begin errors++; $display("FAIL after_drain valid %b ipc %h inst %h exp 1 100 11", inst_valid, inst_pc, inst_out); end
      // OUT without ready, redirect flushes the buffer
      redirect_valid = 1'b1; redirect_target = 32'h200;
      tick();
      redirect_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL out_flush valid %b req %b addr %h exp 0 1 200", inst_valid, imem_req, imem_addr); end
      // REQ with ack and redirect together: rdata dropped, stay in REQ
      imem_ack = 1'b1; imem_rdata = 32'h5555_5555; redirect_valid = 1'b1; redirect_target = 32'h300;
      tick();
      imem_ack = 1'b0; redirect_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300 || inst_out !== 32'h11) begin errors++; $display("FAIL req_ack_redirect valid %b req %b addr %h inst %h exp 0 1 300 11", inst_valid, imem_req, imem_addr, inst_out); end
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_target = 32'h102;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (trap_misalign !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc_out !== 32'h300) begin errors++; $display("FAIL misalign%0d trap %b req %b valid %b pc %h exp 1 0 0 300", i, trap_misalign, imem_req, inst_valid, pc_out); end
         imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h400; inst_ready = 1'b1;
         tick();
         imem_ack = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      checks++; if (trap_misalign !== 1'b0) begin errors++; $display("FAIL misalign_cleared got %b exp 0", trap_misalign); end
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i >= 15) begin
            checks++; if (trap_timeout !== (i == 16) || imem_req !== (i != 16)) begin errors++; $display("FAIL timeout_cyc%0d trap %b req %b exp %b %b", i, trap_timeout, imem_req, i == 16, i != 16); end
         end
      end
      imem_ack = 1'b1;
      tick(); tick();
      imem_ack = 1'b0;
      checks++; if (trap_timeout !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL timeout_halt trap %b req %b valid %b exp 1 0 0", trap_timeout, imem_req, inst_valid); end
   endtask

   task automatic test_rst_in_drain();
      do_reset();
      redirect_valid = 1'b1; redirect_target = 32'h40;
      tick();
      redirect_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;   // late ack lands in BOOT
      tick();
      imem_ack = 1'b0;
      checks++; if (pc_out !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1 || inst_valid !== 1'b0 || inst_out !== 32'h13 || trap_timeout !== 1'b0) begin errors++; $display("FAIL rst_drain pc %h addr %h req %b valid %b inst %h trap %b exp 0 0 1 0 13 0", pc_out, imem_addr, imem_req, inst_valid, inst_out, trap_timeout); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0077;
      tick();
      imem_ack = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'h77) begin errors++; $display("FAIL rst_drain_fetch valid %b ipc %h inst %h exp 1 0 77", inst_valid, inst_pc, inst_out); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_drain();
      test_misalign();
      test_timeout();
      test_rst_in_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
